// File: rtl/billiard_pkg.sv
// Shared fixed-point constants, table geometry and integrator FSM states
// for the billiard physics pipeline.
package billiard_pkg;

    localparam int WIDTH      = 32;
    localparam int FRAC_WIDTH = 30;
    localparam int DT_SHIFT   = 6;
    localparam int FRIC_SHIFT = 8;

    localparam logic signed [WIDTH-1:0] ONE    = 32'sh4000_0000;
    localparam logic signed [WIDTH-1:0] V_EPS  = 32'sh0004_0000;
    localparam logic signed [WIDTH-1:0] X_MIN  = 32'shD000_0000;
    localparam logic signed [WIDTH-1:0] X_MAX  = 32'sh3000_0000;
    localparam logic signed [WIDTH-1:0] Y_MIN  = 32'shE000_0000;
    localparam logic signed [WIDTH-1:0] Y_MAX  = 32'sh2000_0000;
    localparam logic signed [WIDTH-1:0] BALL_R = 32'sh0200_0000;

    typedef enum logic [2:0] {
        IDLE,
        CUE_MOVE,
        CUE_FIN,
        BALL_MOVE,
        BALL_FIN,
        DONE
    } state_t;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis integrator datapath: saturating move, or friction + stop
// threshold + wall bounce on an already-moved position.
module ball_axis_step #(
    parameter int WIDTH      = 32,
    parameter int DT_SHIFT   = 6,
    parameter int FRIC_SHIFT = 8,
    parameter logic signed [WIDTH-1:0] V_EPS  = 32'sh0004_0000,
    parameter logic signed [WIDTH-1:0] P_MIN  = 32'shD000_0000,
    parameter logic signed [WIDTH-1:0] P_MAX  = 32'sh3000_0000,
    parameter logic signed [WIDTH-1:0] BALL_R = 32'sh0200_0000
) (
    input  logic                    i_fin,
    input  logic signed [WIDTH-1:0] i_p,
    input  logic signed [WIDTH-1:0] i_v,
    output logic signed [WIDTH-1:0] o_p,
    output logic signed [WIDTH-1:0] o_v
);

    localparam logic signed [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] P_HI    = P_MAX - BALL_R;
    localparam logic signed [WIDTH-1:0] P_LO    = P_MIN + BALL_R;
    localparam logic signed [WIDTH-1:0] NEG_EPS = -V_EPS;

    logic signed [WIDTH-1:0] w_dp;
    logic signed [WIDTH:0]   w_sum;
    logic signed [WIDTH-1:0] w_p_mv;
    logic signed [WIDTH-1:0] w_v_fr;
    logic signed [WIDTH-1:0] w_v_stop;
    logic signed [WIDTH-1:0] w_v_neg;

    assign w_dp  = i_v >>> DT_SHIFT;
    assign w_sum = {i_p[WIDTH-1], i_p} + {w_dp[WIDTH-1], w_dp};

    // Overflow shows up as the two top bits of the widened sum disagreeing
    always_comb begin
        w_p_mv = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
            w_p_mv = w_sum[WIDTH] ? S_MIN : S_MAX;
        end
    end

    assign w_v_fr = i_v - (i_v >>> FRIC_SHIFT);

    always_comb begin
        w_v_stop = w_v_fr;
        if (w_v_fr > NEG_EPS && w_v_fr < V_EPS) begin
            w_v_stop = '0;
        end
    end

    assign w_v_neg = (w_v_stop == S_MIN) ? S_MAX : -w_v_stop;

    always_comb begin
        o_p = w_p_mv;
        o_v = i_v;
        if (i_fin) begin
            o_p = i_p;
            o_v = w_v_stop;
            if (i_p > P_HI) begin
                o_p = P_HI;
                o_v = w_v_neg;
            end else if (i_p < P_LO) begin
                o_p = P_LO;
                o_v = w_v_neg;
            end
        end
    end

endmodule

// File: rtl/ball_step_integrator.sv
// Two-ball position integrator: cue then object ball, each a move cycle
// followed by a friction/bounce cycle, through one shared x/y datapath.
module ball_step_integrator #(
    parameter int WIDTH      = billiard_pkg::WIDTH,
    parameter int FRAC_WIDTH = billiard_pkg::FRAC_WIDTH,
    parameter int DT_SHIFT   = billiard_pkg::DT_SHIFT,
    parameter int FRIC_SHIFT = billiard_pkg::FRIC_SHIFT,
    parameter logic signed [WIDTH-1:0] V_EPS  = billiard_pkg::V_EPS,
    parameter logic signed [WIDTH-1:0] X_MIN  = billiard_pkg::X_MIN,
    parameter logic signed [WIDTH-1:0] X_MAX  = billiard_pkg::X_MAX,
    parameter logic signed [WIDTH-1:0] Y_MIN  = billiard_pkg::Y_MIN,
    parameter logic signed [WIDTH-1:0] Y_MAX  = billiard_pkg::Y_MAX,
    parameter logic signed [WIDTH-1:0] BALL_R = billiard_pkg::BALL_R
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_valid,
    output logic                    step_ready,
    input  logic signed [WIDTH-1:0] cue_x_in,
    input  logic signed [WIDTH-1:0] cue_y_in,
    input  logic signed [WIDTH-1:0] cue_vx_in,
    input  logic signed [WIDTH-1:0] cue_vy_in,
    input  logic signed [WIDTH-1:0] ball_x_in,
    input  logic signed [WIDTH-1:0] ball_y_in,
    input  logic signed [WIDTH-1:0] ball_vx_in,
    input  logic signed [WIDTH-1:0] ball_vy_in,
    output logic signed [WIDTH-1:0] cue_x,
    output logic signed [WIDTH-1:0] cue_y,
    output logic signed [WIDTH-1:0] cue_vx,
    output logic signed [WIDTH-1:0] cue_vy,
    output logic signed [WIDTH-1:0] ball_x,
    output logic signed [WIDTH-1:0] ball_y,
    output logic signed [WIDTH-1:0] ball_vx,
    output logic signed [WIDTH-1:0] ball_vy,
    output logic                    out_valid
);

    import billiard_pkg::*;

    if (FRAC_WIDTH >= WIDTH || DT_SHIFT >= WIDTH || FRIC_SHIFT >= WIDTH) begin : g_bad_cfg
        $error("ball_step_integrator: shift or fraction width exceeds WIDTH");
    end

    state_t r_state;
    state_t w_next;

    logic signed [WIDTH-1:0] r_cx, r_cy, r_cvx, r_cvy;
    logic signed [WIDTH-1:0] r_bx, r_by, r_bvx, r_bvy;

    logic                    w_is_ball;
    logic                    w_fin;
    logic signed [WIDTH-1:0] w_px_in, w_py_in, w_vx_in, w_vy_in;
    logic signed [WIDTH-1:0] w_px, w_py, w_vx, w_vy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (step_valid) w_next = CUE_MOVE;
            CUE_MOVE:  w_next = CUE_FIN;
            CUE_FIN:   w_next = BALL_MOVE;
            BALL_MOVE: w_next = BALL_FIN;
            BALL_FIN:  w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    assign step_ready = rst && (r_state == IDLE);
    assign out_valid  = rst && (r_state == DONE);

    assign w_is_ball = (r_state == BALL_MOVE) || (r_state == BALL_FIN);
    assign w_fin     = (r_state == CUE_FIN) || (r_state == BALL_FIN);

    assign w_px_in = w_is_ball ? r_bx  : r_cx;
    assign w_py_in = w_is_ball ? r_by  : r_cy;
    assign w_vx_in = w_is_ball ? r_bvx : r_cvx;
    assign w_vy_in = w_is_ball ? r_bvy : r_cvy;

    ball_axis_step #(
        .WIDTH(WIDTH), .DT_SHIFT(DT_SHIFT), .FRIC_SHIFT(FRIC_SHIFT),
        .V_EPS(V_EPS), .P_MIN(X_MIN), .P_MAX(X_MAX), .BALL_R(BALL_R)
    ) u_axis_x (
        .i_fin(w_fin), .i_p(w_px_in), .i_v(w_vx_in),
        .o_p(w_px), .o_v(w_vx)
    );

    ball_axis_step #(
        .WIDTH(WIDTH), .DT_SHIFT(DT_SHIFT), .FRIC_SHIFT(FRIC_SHIFT),
        .V_EPS(V_EPS), .P_MIN(Y_MIN), .P_MAX(Y_MAX), .BALL_R(BALL_R)
    ) u_axis_y (
        .i_fin(w_fin), .i_p(w_py_in), .i_v(w_vy_in),
        .o_p(w_py), .o_v(w_vy)
    );

    // Working registers hold captured state, then intermediate results
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cx    <= '0; r_cy    <= '0; r_cvx   <= '0; r_cvy   <= '0;
            r_bx    <= '0; r_by    <= '0; r_bvx   <= '0; r_bvy   <= '0;
            cue_x   <= '0; cue_y   <= '0; cue_vx  <= '0; cue_vy  <= '0;
            ball_x  <= '0; ball_y  <= '0; ball_vx <= '0; ball_vy <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (step_valid) begin
                        r_cx  <= cue_x_in;   r_cy  <= cue_y_in;
                        r_cvx <= cue_vx_in;  r_cvy <= cue_vy_in;
                        r_bx  <= ball_x_in;  r_by  <= ball_y_in;
                        r_bvx <= ball_vx_in; r_bvy <= ball_vy_in;
                    end
                end
                CUE_MOVE: begin
                    r_cx <= w_px;
                    r_cy <= w_py;
                end
                CUE_FIN: begin
                    r_cx  <= w_px; r_cy  <= w_py;
                    r_cvx <= w_vx; r_cvy <= w_vy;
                end
                BALL_MOVE: begin
                    r_bx <= w_px;
                    r_by <= w_py;
                end
                BALL_FIN: begin
                    r_bx    <= w_px; r_by    <= w_py;
                    r_bvx   <= w_vx; r_bvy   <= w_vy;
                    cue_x   <= r_cx; cue_y   <= r_cy;
                    cue_vx  <= r_cvx; cue_vy <= r_cvy;
                    ball_x  <= w_px; ball_y  <= w_py;
                    ball_vx <= w_vx; ball_vy <= w_vy;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ball_step_integrator.md
BALL_STEP_INTEGRATOR -- requirements
Module: ball_step_integrator

Interface
REQ-001 Parameter WIDTH, 32, fixed-point word width; all values are signed two's complement.
REQ-002 Parameter FRAC_WIDTH, 30, fraction bits; 1.0 = 0x4000_0000.
REQ-003 Parameter DT_SHIFT, 6, time step dt = 2^-DT_SHIFT.
REQ-004 Parameter FRIC_SHIFT, 8, per-step friction v -= v>>>FRIC_SHIFT.
REQ-005 Parameter V_EPS, 0x0004_0000, stop threshold on |v| per axis.
REQ-006 Parameters X_MIN/X_MAX, 0xD000_0000/0x3000_0000, and Y_MIN/Y_MAX, 0xE000_0000/0x2000_0000, table bounds in world coordinates.
REQ-007 Parameter BALL_R, 0x0200_0000, ball radius.
REQ-008 clk  in  1  single clock; all logic is on its rising edge.
REQ-009 rst  in  1  synchronous, active-low reset.
REQ-010 step_valid  in  1  a new physics step is requested with the inputs below.
REQ-011 step_ready  out  1  block is idle and will accept a step.
REQ-012 cue_x_in, cue_y_in, cue_vx_in, cue_vy_in  in  WIDTH each  cue-ball state after the velocity-update stage.
REQ-013 ball_x_in, ball_y_in, ball_vx_in, ball_vy_in  in  WIDTH each  object-ball state after the velocity-update stage.
REQ-014 cue_x, cue_y, cue_vx, cue_vy, ball_x, ball_y, ball_vx, ball_vy  out  WIDTH each  registered integrated state; fed back to the velocity-update stage.
REQ-015 out_valid  out  1  one-cycle pulse: outputs hold a completed step.

Function
REQ-016 The FSM SHALL have the states IDLE, CUE_MOVE, CUE_FIN, BALL_MOVE, BALL_FIN and DONE; step_ready SHALL be 1 only in IDLE.
REQ-017 A step SHALL be accepted on an edge where step_valid=1 and state=IDLE; all eight inputs SHALL be captured on that edge; IDLE then SHALL go to CUE_MOVE.
REQ-018 Transitions SHALL be unconditional: CUE_MOVE->CUE_FIN->BALL_MOVE->BALL_FIN->DONE->IDLE.
REQ-019 out_valid SHALL be 1 only in DONE, i.e. exactly the 5th cycle after the accept edge; a new step is accepted no earlier than the following edge.
REQ-020 step_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-021 MOVE (per axis, per ball): p' = p + (v >>> DT_SHIFT), arithmetic shift; the sum SHALL saturate to 0x7FFF_FFFF / 0x8000_0000.
REQ-022 FIN step a, friction: v' = v - (v >>> FRIC_SHIFT); if |v'| < V_EPS then v' = 0.
REQ-023 FIN step b, wall: if p' > MAX-BALL_R then p' = MAX-BALL_R and v' = -v'; if p' < MIN+BALL_R then p' = MIN+BALL_R and v' = -v'; both axes are independent and evaluated in the same cycle.
REQ-024 Negation of 0x8000_0000 SHALL saturate to 0x7FFF_FFFF.
REQ-025 Output registers SHALL update only on the edge entering DONE and SHALL hold their value until the next DONE.
REQ-026 Ball-ball collision is out of scope; it is handled by a separate stage.

Reset
REQ-027 On an edge with rst=0, the state SHALL go to IDLE, and all eight state outputs and all captured registers SHALL go to 0.
REQ-028 During reset, out_valid SHALL be 0 and step_ready SHALL be 0; step_ready SHALL become 1 in the first cycle after rst=1.
REQ-029 Reset mid-step SHALL abandon the step with no out_valid pulse.

Structure
REQ-030 The shared package billiard_pkg SHALL hold WIDTH, FRAC_WIDTH, the constant ONE, the table bounds, BALL_R and the FSM state enum.
REQ-031 Sub-module ball_axis_step SHALL be a combinational one-axis move/friction/bounce datapath with saturation, instanced twice (x, y) and shared by both balls across the FSM states.

Verification
REQ-032 The bench SHALL cover: cue x=0, vx=0x4000_0000, others 0 -> cue_x=0x0100_0000, cue_vx=0x3FC0_0000, out_valid 5 cycles after accept.
REQ-033 The bench SHALL cover: ball x=0x2E00_0000, vx=0x4000_0000 -> ball_x=0x2E00_0000, ball_vx=0xC040_0000.
REQ-034 The bench SHALL cover: cue vy=0x0003_0000, y=0 -> cue_y=0x0000_0C00, cue_vy=0.
REQ-035 The bench SHALL cover: step_valid held high continuously -> one accept per 6 cycles, step_ready low for 5 cycles, single-cycle out_valid pulses.
REQ-036 The bench SHALL cover: rst=0 asserted in BALL_MOVE -> no out_valid, all outputs 0, step_ready=1 the first cycle after release.
REQ-037 The bench SHALL cover: x=0x7FFF_0000, vx=0x7FFF_FFFF with X_MAX=0x7FFF_FFFF -> x saturates, then clamps to X_MAX-BALL_R, and no wraparound occurs.
